// File: rtl/riscv_pkg.sv
// Shared pipeline types: register addresses, forwarding selects, shadow-stage payloads.
package riscv_pkg;

  localparam int unsigned REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    reg_addr_t rd;
    logic      regwrite;
    logic      is_load;
  } stage_ctl_t;

  // One shadow pipeline entry; only stage E makes use of the source fields.
  typedef struct packed {
    reg_addr_t  rs1;
    reg_addr_t  rs2;
    stage_ctl_t ctl;
  } shadow_t;

  localparam shadow_t BUBBLE = '0;

  // Operand select: the younger producer (MEM) wins over WB, x0 is never forwarded.
  function automatic fwd_sel_t fwd_select(reg_addr_t rs, stage_ctl_t m, stage_ctl_t w);
    if ((rs != '0) && m.regwrite && (m.rd == rs)) begin
      return FWD_MEM;
    end
    if ((rs != '0) && w.regwrite && (w.rd == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: hold has priority over flush, flush loads a bubble.
module hazard_stage_reg
  import riscv_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    hold,
  input  logic    flush,
  input  shadow_t d,
  output shadow_t q
);

  // Stage register; reset drops the in-flight entry immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= BUBBLE;
    end else if (!hold) begin
      q <= flush ? BUBBLE : d;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding selects and stall/flush control for the 5-stage pipeline, with a
// private shadow copy of the E/M/W destination info and a stall-cycle counter.
module forward_hazard_unit
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              regwrite_d,
  input  logic              is_load_d,
  input  logic              pcsrc_e,
  input  logic              mem_wait,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [CNT_W-1:0]  stall_cnt
);

  shadow_t id_s;
  shadow_t e_q;
  shadow_t m_d;
  shadow_t m_q;
  shadow_t w_q;
  logic    lwstall;
  logic    unused_w;

  assign id_s = '{rs1: rs1_d, rs2: rs2_d,
                  ctl: '{rd: rd_d, regwrite: regwrite_d, is_load: is_load_d}};

  // M and W only need the destination and write enable.
  assign m_d = '{rs1: '0, rs2: '0,
                 ctl: '{rd: e_q.ctl.rd, regwrite: e_q.ctl.regwrite, is_load: 1'b0}};

  assign unused_w = ^{w_q.rs1, w_q.rs2, w_q.ctl.is_load};

  hazard_stage_reg u_stage_e (
    .clk   (clk),
    .reset (reset),
    .hold  (mem_wait),
    .flush (flush_e),
    .d     (id_s),
    .q     (e_q)
  );

  hazard_stage_reg u_stage_m (
    .clk   (clk),
    .reset (reset),
    .hold  (mem_wait),
    .flush (1'b0),
    .d     (m_d),
    .q     (m_q)
  );

  hazard_stage_reg u_stage_w (
    .clk   (clk),
    .reset (reset),
    .hold  (mem_wait),
    .flush (1'b0),
    .d     (m_q),
    .q     (w_q)
  );

  assign forward_a_e = 2'(fwd_select(e_q.rs1, m_q.ctl, w_q.ctl));
  assign forward_b_e = 2'(fwd_select(e_q.rs2, m_q.ctl, w_q.ctl));

  // Load-use detection and stall/flush equations; all forced low during reset.
  always_comb begin
    lwstall = 1'b0;
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    lwstall = e_q.ctl.is_load && (e_q.ctl.rd != '0) &&
              ((rs1_d == e_q.ctl.rd) || (rs2_d == e_q.ctl.rd));
    if (!reset) begin
      stall_f = lwstall | mem_wait;
      stall_d = lwstall | mem_wait;
      flush_d = pcsrc_e & ~mem_wait;
      flush_e = (lwstall | pcsrc_e) & ~mem_wait;
    end
  end

  // Saturating count of cycles in which the fetch stage is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_f && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
